// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked add/subtract unit.
// Holds FSM encodings, mode constants and the saturation-value helper.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   localparam int SAT_MAXW = 64;

   // Most positive value for a non-negative A, most negative otherwise
   function automatic logic [SAT_MAXW-1:0] sat_value(
      input logic sign,
      input int   width
   );
      logic [SAT_MAXW-1:0] msb;
      msb = SAT_MAXW'(1) << (width - 1);
      return sign ? msb : msb - SAT_MAXW'(1);
   endfunction

endpackage

// File: rtl/chunked_addsub_unit_if.sv
// Operand/result handshake bundle for the chunked add/subtract unit.
// The producer/consumer side is master, the arithmetic unit is slave.
interface chunked_addsub_unit_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             M;
   logic             sat;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] C;
   logic             cout;
   logic             V;
   logic             Z;
   logic             N;

   modport master (
      output in_valid, M, sat, A, B, out_ready,
      input  in_ready, out_valid, C, cout, V, Z, N
   );

   modport slave (
      input  in_valid, M, sat, A, B, out_ready,
      output in_ready, out_valid, C, cout, V, Z, N
   );
endinterface

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder built from full-adder cells.
// Also exposes the carry into its top bit for overflow detection.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] A,
   input  logic [CHUNK-1:0] X,
   input  logic             Cin,
   output logic [CHUNK-1:0] Sum,
   output logic             Cout,
   output logic             Cmsb
);

   logic [CHUNK:0] c;

   assign c[0] = Cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign Sum[i]  = A[i] ^ X[i] ^ c[i];
      assign c[i+1]  = (A[i] & X[i]) | (c[i] & (A[i] ^ X[i]));
   end

   assign Cout = c[CHUNK];
   assign Cmsb = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub_unit.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per cycle through a
// single shared ripple adder, with flags and optional saturation.
module chunked_addsub_unit
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                  clk,
   input logic                  rst,
   chunked_addsub_unit_if.slave io
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = $clog2(NCHUNK) + 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("WIDTH must be a multiple of CHUNK");
   end
   if (WIDTH > SAT_MAXW) begin : g_bad_width
      $error("WIDTH exceeds saturation helper range");
   end

   state_e           state_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             sat_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] c_q;
   logic             cout_q;
   logic             v_q;
   logic             z_q;
   logic             n_q;

   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] x_sl;
   logic [CHUNK-1:0] ca_sum;
   logic             ca_cout;
   logic             ca_cmsb;

   logic [SAT_MAXW-1:0] sat_full;
   logic [WIDTH-1:0]    sat_c;
   logic                unused_sat;
   logic [WIDTH-1:0]    res;
   logic [WIDTH-1:0]    fin;
   logic                ovf;

   assign a_sl = a_q[idx_q*CHUNK +: CHUNK];
   assign x_sl = x_q[idx_q*CHUNK +: CHUNK];

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .A    (a_sl),
      .X    (x_sl),
      .Cin  (carry_q),
      .Sum  (ca_sum),
      .Cout (ca_cout),
      .Cmsb (ca_cmsb)
   );

   assign sat_full   = sat_value(a_q[WIDTH-1], WIDTH);
   assign sat_c      = sat_full[WIDTH-1:0];
   assign unused_sat = ^sat_full;

   // On the last chunk the adder's own carries are the MSB carries
   always_comb begin
      res = sum_q;
      res[idx_q*CHUNK +: CHUNK] = ca_sum;
      ovf = ca_cmsb ^ ca_cout;
      fin = (sat_q && ovf) ? sat_c : res;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         x_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         c_q         <= '0;
         cout_q      <= 1'b0;
         v_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (io.in_valid && in_ready_q) begin
                  a_q        <= io.A;
                  x_q        <= io.B ^ {WIDTH{io.M}};
                  carry_q    <= (io.M == MODE_SUB);
                  sat_q      <= io.sat;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               sum_q[idx_q*CHUNK +: CHUNK] <= ca_sum;
               carry_q <= ca_cout;
               if (idx_q == LAST) begin
                  idx_q       <= '0;
                  c_q         <= fin;
                  cout_q      <= ca_cout;
                  v_q         <= ovf;
                  z_q         <= (fin == '0);
                  n_q         <= fin[WIDTH-1];
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (io.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               idx_q       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign io.in_ready  = in_ready_q;
   assign io.out_valid = out_valid_q;
   assign io.C         = c_q;
   assign io.cout      = cout_q;
   assign io.V         = v_q;
   assign io.Z         = z_q;
   assign io.N         = n_q;

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Scoreboard bench: three units (CHUNK 4, 16, 1) share stimulus and are
// checked against an arithmetic reference model.
module tb_chunked_addsub_unit;

   localparam int W    = 16;
   localparam int NDUT = 3;
   localparam int CHS[NDUT] = '{4, 16, 1};

   typedef struct {
      logic [W-1:0] c;
      logic         cout;
      logic         v;
      logic         z;
      logic         n;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int ormode = 1;

   logic [W-1:0]    A_s = '0;
   logic [W-1:0]    B_s = '0;
   logic            M_s = 1'b0;
   logic            sat_s = 1'b0;
   logic [NDUT-1:0] iv = '0;
   logic [NDUT-1:0] ordy = '1;
   logic [NDUT-1:0] rdy, ov, fco, fv, fz, fn;
   logic [W-1:0]    cres[NDUT];

   exp_t q[NDUT][$];
   bit   seen[NDUT];
   int   last_acc[NDUT];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input int k,
                      input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s dut%0d actual=%h required=%h", nm, k, act, req);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic m, input logic s, input int acc);
      exp_t e;
      int sa, sb, r;
      logic [W-1:0] sum;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (m) begin
         r = sa - sb;
         sum = a - b;
         e.cout = (a >= b);
      end else begin
         r = sa + sb;
         sum = a + b;
         e.cout = (int'(a) + int'(b)) > 65535;
      end
      e.v = (r > 32767) || (r < -32768);
      e.c = (s && e.v) ? ((sa < 0) ? 16'h8000 : 16'h7FFF) : sum;
      e.z = (e.c == '0);
      e.n = e.c[W-1];
      e.acc = acc;
      return e;
   endfunction

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      chunked_addsub_unit_if #(.WIDTH(W)) bus ();

      assign bus.in_valid  = iv[k];
      assign bus.M         = M_s;
      assign bus.sat       = sat_s;
      assign bus.A         = A_s;
      assign bus.B         = B_s;
      assign bus.out_ready = ordy[k];
      assign rdy[k]        = bus.in_ready;
      assign ov[k]         = bus.out_valid;
      assign cres[k]       = bus.C;
      assign fco[k]        = bus.cout;
      assign fv[k]         = bus.V;
      assign fz[k]         = bus.Z;
      assign fn[k]         = bus.N;

      chunked_addsub_unit #(
         .WIDTH (W),
         .CHUNK (CHS[k])
      ) dut (
         .clk (clk),
         .rst (rst),
         .io  (bus)
      );

      initial begin : mon
         exp_t e;
         forever begin
            @(negedge clk);
            if (!rst && ov[k]) begin
               if (q[k].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL spurious_out dut%0d actual=%h required=none", k, cres[k]);
               end else begin
                  e = q[k][0];
                  chk("result_flags", k, {cres[k], fco[k], fv[k], fz[k], fn[k]},
                      {e.c, e.cout, e.v, e.z, e.n});
                  chk("in_ready_done", k, rdy[k], 0);
                  if (!seen[k]) chk("latency", k, cyc - e.acc, W / CHS[k]);
                  seen[k] = 1'b1;
                  if (ordy[k]) begin
                     void'(q[k].pop_front());
                     seen[k] = 1'b0;
                  end
               end
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (ormode == 0) ordy = NDUT'($urandom);
      else if (ormode == 1) ordy = '1;
      else ordy = '0;
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic s);
      logic [NDUT-1:0] pend;
      int t;
      A_s = a; B_s = b; M_s = m; sat_s = s;
      pend = '1; iv = '1; t = 0;
      while (pend != '0 && t < 300) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++)
            if (pend[k] && rdy[k]) begin
               q[k].push_back(model(a, b, m, s, cyc + 1));
               pend[k] = 1'b0;
            end
         @(posedge clk);
         #1;
         iv = pend;
         t++;
      end
      if (pend != '0) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=%b required=000", pend);
         iv = '0;
      end
      // scramble inputs while the slower units are still running
      A_s = W'($urandom); B_s = W'($urandom);
      M_s = 1'($urandom); sat_s = 1'($urandom);
   endtask

   task automatic b2b(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic m, input logic s, input int n);
      int d, nc;
      A_s = a; B_s = b; M_s = m; sat_s = s;
      for (int k = 0; k < NDUT; k++) last_acc[k] = -1;
      iv = '1;
      repeat (n) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++)
            if (rdy[k]) begin
               q[k].push_back(model(a, b, m, s, cyc + 1));
               if (last_acc[k] >= 0) begin
                  d = cyc + 1 - last_acc[k];
                  nc = W / CHS[k];
                  checks++;
                  if (d < nc + 1 || d > nc + 2) begin
                     failures++;
                     $display("FAIL issue_interval dut%0d actual=%0d required=%0d..%0d",
                              k, d, nc + 1, nc + 2);
                  end
               end
               last_acc[k] = cyc + 1;
            end
         @(posedge clk);
         #1;
      end
      iv = '0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q[0].size() + q[1].size() + q[2].size() != 0 || ov != '0) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", q[0].size() + q[1].size() + q[2].size());
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'hFFFF;
         3: return 16'h0000;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic check_reset_state(input string tag);
      for (int k = 0; k < NDUT; k++) begin
         chk({tag, "_in_ready"}, k, rdy[k], 1);
         chk({tag, "_out_valid"}, k, ov[k], 0);
         chk({tag, "_result"}, k, {cres[k], fco[k], fv[k], fz[k], fn[k]}, 0);
      end
   endtask

   initial begin
      int t;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      issue(16'h0005, 16'h0005, 1'b1, 1'b0);
      issue(16'h0003, 16'h0005, 1'b1, 1'b0);
      issue(16'h8000, 16'h0001, 1'b1, 1'b1);
      issue(16'h8000, 16'h0001, 1'b1, 1'b0);
      drain();

      // hold results under back-pressure, then release
      ormode = 2;
      ordy = '0;
      issue(16'h1234, 16'h0F0F, 1'b0, 1'b0);
      t = 0;
      while (ov != '1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("all_valid_wait", 0, ov, 3'b111);
      repeat (3) @(posedge clk);
      #1;
      ormode = 1;
      ordy = '1;
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("release_out_valid", k, ov[k], 0);
         chk("release_in_ready", k, rdy[k], 1);
      end
      drain();

      b2b(16'h4000, 16'h4000, 1'b0, 1'b1, 60);
      drain();

      // asynchronous reset while the CHUNK=4 unit sits at idx 2
      issue(16'h4321, 16'h1111, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_state("midrun_reset");
      for (int k = 0; k < NDUT; k++) begin
         q[k].delete();
         seen[k] = 1'b0;
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(16'h0100, 16'h0001, 1'b1, 1'b0);
      drain();

      ormode = 0;
      repeat (60) issue(pick(), pick(), 1'($urandom), 1'($urandom));
      drain();
      ormode = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
